rob_retire: RTL and testbench

In-order reorder/retire buffer paired with the register-rename stage. It assigns ROB ids to each renamed packet of INSTR_COUNT instructions and records lreg/preg/ppreg per entry. It marks entries done on writeback, squashes younger entries on flush, and commits up to INSTR_COUNT done entries per cycle in program order. Committed ppregs are returned to the rename free list, closing the loop from rename allocation back to release.

---
 rtl/rob_retire_pkg.sv | 43 ++++
 rtl/rob_retire_if.sv | 38 +++
 rtl/rob_commit_select.sv | 25 ++
 rtl/rob_retire.sv | 119 +++++++++++
 tb/tb_rob_retire.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/rob_retire_pkg.sv
// Shared constants, entry layout and wrap-around id arithmetic for the
// reorder/retire buffer.
package rob_retire_pkg;

    localparam int P_REGISTERS = 64;
    localparam int L_REGISTERS = 32;
    localparam int C_NUM       = 4;
    localparam int K           = 32;
    localparam int INSTR_COUNT = 2;

    localparam int ROB_DEPTH = (C_NUM - 1) * K;
    localparam int RID_W     = $clog2(ROB_DEPTH);
    localparam int PR_W      = $clog2(P_REGISTERS);
    localparam int LR_W      = $clog2(L_REGISTERS);
    localparam int CNT_W     = $clog2(ROB_DEPTH + 1);
    localparam int NC_W      = $clog2(INSTR_COUNT + 1);

    typedef logic [RID_W-1:0] rid_t;

    typedef struct packed {
        logic [LR_W-1:0] lreg;
        logic [PR_W-1:0] preg;
        logic [PR_W-1:0] ppreg;
        logic            valid;
        logic            done;
    } rob_entry_s;

    // Depth is not a power of two, so ids wrap explicitly at ROB_DEPTH.
    function automatic rid_t rid_add(input rid_t id, input rid_t n);
        logic [RID_W:0] s;
        s = {1'b0, id} + {1'b0, n};
        if (s >= (RID_W+1)'(ROB_DEPTH)) s = s - (RID_W+1)'(ROB_DEPTH);
        return s[RID_W-1:0];
    endfunction

    function automatic rid_t rid_dist(input rid_t from_id, input rid_t to_id);
        logic [RID_W:0] d;
        if (to_id >= from_id) d = {1'b0, to_id} - {1'b0, from_id};
        else                  d = {1'b0, to_id} + (RID_W+1)'(ROB_DEPTH) - {1'b0, from_id};
        return d[RID_W-1:0];
    endfunction

endpackage

// File: rtl/rob_retire_if.sv
// Rename/writeback/flush/commit signal bundle around the retire buffer.
// Handshake: a packet transfers on a rising clk edge where alloc_valid && alloc_ready.
interface rob_retire_if;
    import rob_retire_pkg::*;

    logic                             alloc_valid;
    logic                             alloc_ready;
    logic [INSTR_COUNT-1:0][LR_W-1:0] alloc_lreg;
    logic [INSTR_COUNT-1:0][PR_W-1:0] alloc_preg;
    logic [INSTR_COUNT-1:0][PR_W-1:0] alloc_ppreg;
    rid_t [INSTR_COUNT-1:0]           alloc_rob_id;
    logic [INSTR_COUNT-1:0]           wb_en;
    rid_t [INSTR_COUNT-1:0]           wb_rob_id;
    logic                             flush_en;
    rid_t                             flush_rob_id;
    logic [INSTR_COUNT-1:0]           commit_valid;
    logic [INSTR_COUNT-1:0][LR_W-1:0] commit_lreg;
    logic [INSTR_COUNT-1:0][PR_W-1:0] commit_preg;
    logic [INSTR_COUNT-1:0][PR_W-1:0] commit_ppreg;
    rid_t [INSTR_COUNT-1:0]           commit_rob_id;
    logic                             rob_empty;
    logic [CNT_W-1:0]                 rob_count;

    modport master (
        output alloc_valid, alloc_lreg, alloc_preg, alloc_ppreg,
               wb_en, wb_rob_id, flush_en, flush_rob_id,
        input  alloc_ready, alloc_rob_id, commit_valid, commit_lreg,
               commit_preg, commit_ppreg, commit_rob_id, rob_empty, rob_count
    );

    modport slave (
        input  alloc_valid, alloc_lreg, alloc_preg, alloc_ppreg,
               wb_en, wb_rob_id, flush_en, flush_rob_id,
        output alloc_ready, alloc_rob_id, commit_valid, commit_lreg,
               commit_preg, commit_ppreg, commit_rob_id, rob_empty, rob_count
    );

endinterface

// File: rtl/rob_commit_select.sv
// In-order commit mask over the oldest INSTR_COUNT entries: a slot retires
// only when it and every older slot are valid and done.
module rob_commit_select
    import rob_retire_pkg::*;
(
    input  logic [INSTR_COUNT-1:0] head_valid_i,
    input  logic [INSTR_COUNT-1:0] head_done_i,
    output logic [INSTR_COUNT-1:0] commit_mask_o,
    output logic [NC_W-1:0]        n_commit_o
);

    logic run;

    always_comb begin
        run           = 1'b1;
        commit_mask_o = '0;
        n_commit_o    = '0;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            run              = run & head_valid_i[i] & head_done_i[i];
            commit_mask_o[i] = run;
            if (run) n_commit_o = n_commit_o + NC_W'(1);
        end
    end

endmodule

// File: rtl/rob_retire.sv
// In-order reorder/retire buffer: allocates ids per renamed packet, tracks
// writeback, squashes on flush and returns committed ppregs in program order.
module rob_retire
    import rob_retire_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    rob_retire_if.slave  bus
);

    rob_entry_s                       rob_q [ROB_DEPTH];
    rid_t                             head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [INSTR_COUNT-1:0]           commit_valid_q;
    logic [INSTR_COUNT-1:0][LR_W-1:0] commit_lreg_q;
    logic [INSTR_COUNT-1:0][PR_W-1:0] commit_preg_q, commit_ppreg_q;
    rid_t [INSTR_COUNT-1:0]           commit_rob_id_q;

    rid_t [INSTR_COUNT-1:0]           alloc_id, head_id;
    rob_entry_s [INSTR_COUNT-1:0]     head_ent;
    logic [INSTR_COUNT-1:0]           head_valid, head_done, commit_mask;
    logic [NC_W-1:0]                  n_commit;
    logic [ROB_DEPTH-1:0]             squash;
    rid_t                             flush_dist;
    logic                             alloc_fire;

    assign bus.alloc_ready = (count_q <= CNT_W'(ROB_DEPTH - INSTR_COUNT)) && !bus.flush_en;
    assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;

    always_comb begin
        for (int i = 0; i < INSTR_COUNT; i++) begin
            alloc_id[i]   = rid_add(tail_q, RID_W'(i));
            head_id[i]    = rid_add(head_q, RID_W'(i));
            head_ent[i]   = rob_q[head_id[i]];
            head_valid[i] = head_ent[i].valid;
            head_done[i]  = head_ent[i].done;
        end
    end

    rob_commit_select u_sel (
        .head_valid_i  (head_valid),
        .head_done_i   (head_done),
        .commit_mask_o (commit_mask),
        .n_commit_o    (n_commit)
    );

    // An entry is younger than the flush point when it lies further from head.
    always_comb begin
        flush_dist = rid_dist(head_q, bus.flush_rob_id);
        for (int j = 0; j < ROB_DEPTH; j++)
            squash[j] = bus.flush_en && (rid_dist(head_q, RID_W'(j)) > flush_dist);
    end

    always_comb begin
        head_d = rid_add(head_q, RID_W'(n_commit));
        if (bus.flush_en) begin
            tail_d  = rid_add(bus.flush_rob_id, RID_W'(1));
            count_d = CNT_W'(flush_dist) + CNT_W'(1) - CNT_W'(n_commit);
        end else begin
            tail_d  = alloc_fire ? rid_add(tail_q, RID_W'(INSTR_COUNT)) : tail_q;
            count_d = count_q + (alloc_fire ? CNT_W'(INSTR_COUNT) : CNT_W'(0)) - CNT_W'(n_commit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < ROB_DEPTH; j++) rob_q[j] <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_valid_q  <= '0;
            commit_lreg_q   <= '0;
            commit_preg_q   <= '0;
            commit_ppreg_q  <= '0;
            commit_rob_id_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (alloc_fire) begin
                for (int i = 0; i < INSTR_COUNT; i++)
                    rob_q[alloc_id[i]] <= '{lreg: bus.alloc_lreg[i], preg: bus.alloc_preg[i],
                                            ppreg: bus.alloc_ppreg[i], valid: 1'b1, done: 1'b0};
            end
            for (int i = 0; i < INSTR_COUNT; i++) begin
                if (bus.wb_en[i] && (bus.wb_rob_id[i] < RID_W'(ROB_DEPTH)) && rob_q[bus.wb_rob_id[i]].valid)
                    rob_q[bus.wb_rob_id[i]].done <= 1'b1;
                if (commit_mask[i]) begin
                    rob_q[head_id[i]].valid <= 1'b0;
                    rob_q[head_id[i]].done  <= 1'b0;
                end
            end
            // Placed last so a same-cycle writeback to a squashed entry is lost.
            for (int j = 0; j < ROB_DEPTH; j++) begin
                if (squash[j]) begin
                    rob_q[j].valid <= 1'b0;
                    rob_q[j].done  <= 1'b0;
                end
            end
            commit_valid_q <= commit_mask;
            for (int i = 0; i < INSTR_COUNT; i++) begin
                commit_lreg_q[i]   <= commit_mask[i] ? head_ent[i].lreg  : '0;
                commit_preg_q[i]   <= commit_mask[i] ? head_ent[i].preg  : '0;
                commit_ppreg_q[i]  <= commit_mask[i] ? head_ent[i].ppreg : '0;
                commit_rob_id_q[i] <= commit_mask[i] ? head_id[i]        : '0;
            end
        end
    end

    assign bus.alloc_rob_id  = alloc_id;
    assign bus.commit_valid  = commit_valid_q;
    assign bus.commit_lreg   = commit_lreg_q;
    assign bus.commit_preg   = commit_preg_q;
    assign bus.commit_ppreg  = commit_ppreg_q;
    assign bus.commit_rob_id = commit_rob_id_q;
    assign bus.rob_empty     = (count_q == '0);
    assign bus.rob_count     = count_q;

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: allocation, writeback ordering, wrap,
// flush, simultaneous flush/alloc/commit and mid-run reset.
module tb_rob_retire;
  import rob_retire_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  rob_retire_if bus ();

  rob_retire dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pr(input int hi, input int lo, input int w);
    return (64'(hi) << w) | 64'(lo);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.alloc_valid  = 1'b0;
    bus.alloc_lreg   = '0;
    bus.alloc_preg   = '0;
    bus.alloc_ppreg  = '0;
    bus.wb_en        = '0;
    bus.wb_rob_id    = '0;
    bus.flush_en     = 1'b0;
    bus.flush_rob_id = '0;
  endtask

  task automatic alloc_pkt(input int l0, input int l1, input int p0, input int p1,
                           input int q0, input int q1);
    bus.alloc_valid    = 1'b1;
    bus.alloc_lreg[0]  = LR_W'(l0);
    bus.alloc_lreg[1]  = LR_W'(l1);
    bus.alloc_preg[0]  = PR_W'(p0);
    bus.alloc_preg[1]  = PR_W'(p1);
    bus.alloc_ppreg[0] = PR_W'(q0);
    bus.alloc_ppreg[1] = PR_W'(q1);
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic wb(input logic e0, input int i0, input logic e1, input int i1);
    bus.wb_en[0]     = e0;
    bus.wb_rob_id[0] = RID_W'(i0);
    bus.wb_en[1]     = e1;
    bus.wb_rob_id[1] = RID_W'(i1);
    tick();
    bus.wb_en = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    repeat (2) tick();
    rst = 1'b0;
    #1;

    // reset state
    chk("rst_empty", bus.rob_empty, 1);
    chk("rst_count", bus.rob_count, 0);
    chk("rst_alloc_id", bus.alloc_rob_id, pr(1, 0, RID_W));
    chk("rst_ready", bus.alloc_ready, 1);
    chk("rst_cvalid", bus.commit_valid, 0);

    // single packet round trip
    alloc_pkt(3, 7, 40, 41, 3, 7);
    chk("t1_count", bus.rob_count, 2);
    chk("t1_next_id", bus.alloc_rob_id, pr(3, 2, RID_W));
    wb(1, 0, 1, 1);
    chk("t1_no_commit_yet", bus.commit_valid, 0);
    tick();
    chk("t1_cvalid", bus.commit_valid, 2'b11);
    chk("t1_cppreg", bus.commit_ppreg, pr(7, 3, PR_W));
    chk("t1_cpreg", bus.commit_preg, pr(41, 40, PR_W));
    chk("t1_cid", bus.commit_rob_id, pr(1, 0, RID_W));
    chk("t1_empty", bus.rob_empty, 1);
    tick();
    chk("t1_cvalid_drop", bus.commit_valid, 0);

    // out-of-order writeback
    do_reset();
    alloc_pkt(1, 2, 10, 11, 20, 21);
    alloc_pkt(3, 4, 12, 13, 22, 23);
    wb(1, 1, 0, 0);
    tick();
    chk("t2_blocked", bus.commit_valid, 0);
    chk("t2_count4", bus.rob_count, 4);
    wb(1, 0, 0, 0);
    tick();
    chk("t2_cvalid01", bus.commit_valid, 2'b11);
    chk("t2_cid01", bus.commit_rob_id, pr(1, 0, RID_W));
    chk("t2_cppreg01", bus.commit_ppreg, pr(21, 20, PR_W));
    chk("t2_count2", bus.rob_count, 2);
    wb(1, 3, 1, 2);
    chk("t2_gap", bus.commit_valid, 0);
    tick();
    chk("t2_cvalid23", bus.commit_valid, 2'b11);
    chk("t2_cid23", bus.commit_rob_id, pr(3, 2, RID_W));
    chk("t2_clreg23", bus.commit_lreg, pr(4, 3, LR_W));
    tick();
    chk("t2_empty", bus.rob_empty, 1);

    // fill to full and wrap
    do_reset();
    for (int k = 0; k < 47; k++) alloc_pkt(k % 32, (k + 1) % 32, k, k + 1, k, k + 1);
    chk("t3_ready94", bus.alloc_ready, 1);
    chk("t3_last_id", bus.alloc_rob_id, pr(95, 94, RID_W));
    alloc_pkt(5, 6, 50, 51, 60, 61);
    chk("t3_full_count", bus.rob_count, 96);
    chk("t3_full_ready", bus.alloc_ready, 0);
    chk("t3_wrap_id", bus.alloc_rob_id, pr(1, 0, RID_W));
    wb(1, 0, 1, 1);
    chk("t3_still_full", bus.alloc_ready, 0);
    tick();
    chk("t3_cvalid", bus.commit_valid, 2'b11);
    chk("t3_count94", bus.rob_count, 94);
    chk("t3_ready_again", bus.alloc_ready, 1);
    alloc_pkt(8, 9, 30, 31, 32, 33);
    chk("t3_refill", bus.rob_count, 96);
    chk("t3_after_wrap_id", bus.alloc_rob_id, pr(3, 2, RID_W));

    // flush with head=10, tail=20
    do_reset();
    for (int k = 0; k < 10; k++) alloc_pkt(k, k + 1, k + 2, k + 3, k + 4, k + 5);
    for (int k = 0; k < 5; k++) wb(1, 2 * k, 1, 2 * k + 1);
    tick();
    chk("t4_count10", bus.rob_count, 10);
    bus.flush_en     = 1'b1;
    bus.flush_rob_id = RID_W'(13);
    #1;
    chk("t4_flush_ready", bus.alloc_ready, 0);
    tick();
    bus.flush_en = 1'b0;
    chk("t4_count4", bus.rob_count, 4);
    chk("t4_tail_id", bus.alloc_rob_id, pr(15, 14, RID_W));
    wb(1, 15, 0, 0);
    tick();
    chk("t4_squashed_wb", bus.commit_valid, 0);
    chk("t4_count_kept", bus.rob_count, 4);

    // flush + alloc + commit in one cycle
    alloc_pkt(1, 2, 3, 4, 5, 6);
    chk("t5_count6", bus.rob_count, 6);
    wb(1, 10, 1, 11);
    bus.flush_en       = 1'b1;
    bus.flush_rob_id   = RID_W'(13);
    bus.alloc_valid    = 1'b1;
    bus.wb_en          = 2'b11;
    bus.wb_rob_id[0]   = RID_W'(12);
    bus.wb_rob_id[1]   = RID_W'(14);
    #1;
    chk("t5_ready_low", bus.alloc_ready, 0);
    tick();
    idle();
    chk("t5_cvalid", bus.commit_valid, 2'b11);
    chk("t5_cid", bus.commit_rob_id, pr(11, 10, RID_W));
    chk("t5_count2", bus.rob_count, 2);
    chk("t5_tail_id", bus.alloc_rob_id, pr(15, 14, RID_W));
    tick();
    chk("t5_cvalid12", bus.commit_valid, 2'b01);
    chk("t5_cid12", bus.commit_rob_id[0], 12);
    chk("t5_count1", bus.rob_count, 1);

    // reset while 30 entries pending
    do_reset();
    for (int k = 0; k < 15; k++) alloc_pkt(k, k, k, k, k, k);
    chk("t6_count30", bus.rob_count, 30);
    wb(1, 0, 1, 1);
    tick();
    chk("t6_cvalid_pre", bus.commit_valid, 2'b11);
    rst = 1'b1;
    #1;
    chk("t6_cvalid_rst", bus.commit_valid, 0);
    chk("t6_empty_rst", bus.rob_empty, 1);
    chk("t6_id_rst", bus.alloc_rob_id, pr(1, 0, RID_W));
    chk("t6_count_rst", bus.rob_count, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_cvalid_after", bus.commit_valid, 0);
    chk("t6_empty_after", bus.rob_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
